// File: rtl/lcd_ctrl_if.sv
// Bundles the LSU LCD register and the HD44780-style bus/status signals.
// The slave side is the controller; the master side is the LSU/bench.
interface lcd_ctrl_if;
    logic [31:0] lcd_reg_i;
    logic        lcd_on_o;
    logic        lcd_en_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic [7:0]  lcd_data_o;
    logic        lcd_busy_o;
    logic        init_done_o;
    logic        lcd_ovf_o;

    modport master (
        output lcd_reg_i,
        input  lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o,
        input  lcd_busy_o, init_done_o, lcd_ovf_o
    );

    modport slave (
        input  lcd_reg_i,
        output lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o,
        output lcd_busy_o, init_done_o, lcd_ovf_o
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus sequencer: power-up wait, 4-command init, then CPU commands.
// States: PWR_WAIT power-up delay | SETUP/EN_HI/HOLD bus phases | EXEC command wait | IDLE
module lcd_ctrl #(
    parameter int unsigned T_PWRUP_CYC = 750000,
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_CLR_CYC   = 82000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    lcd_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {PWR_WAIT, SETUP, EN_HI, HOLD, EXEC, IDLE} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        go_q, go_d;
    logic        on_q, on_d;
    logic        cur_rs_q, cur_rs_d;
    logic [7:0]  cur_data_q, cur_data_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_rs_q, pend_rs_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [1:0]  idx_q, idx_d;
    logic        init_done_q, init_done_d;
    logic        ovf_q, ovf_d;

    logic        go_pulse;
    logic        launch;
    logic        pop;
    logic        tc;
    logic [31:0] exec_len;
    logic        unused_bits;

    function automatic logic [7:0] init_rom(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    always_comb begin
        go_pulse = bus.lcd_reg_i[10] & ~go_q;
        launch   = (state_q == IDLE) & ~pend_valid_q & go_pulse;
        // clear/home commands need the long execution wait
        exec_len = (!cur_rs_q && (cur_data_q inside {8'h01, 8'h02, 8'h03})) ? T_CLR_CYC : T_EXEC_CYC;

        case (state_q)
            PWR_WAIT: tc = (cnt_q == T_PWRUP_CYC - 1);
            SETUP:    tc = (cnt_q == T_SETUP_CYC - 1);
            EN_HI:    tc = (cnt_q == T_EN_CYC - 1);
            HOLD:     tc = (cnt_q == T_HOLD_CYC - 1);
            EXEC:     tc = (cnt_q == exec_len - 32'd1);
            default:  tc = 1'b0;
        endcase

        state_d      = state_q;
        cnt_d        = cnt_q + 32'd1;
        go_d         = bus.lcd_reg_i[10];
        on_d         = bus.lcd_reg_i[31];
        cur_rs_d     = cur_rs_q;
        cur_data_d   = cur_data_q;
        pend_valid_d = pend_valid_q;
        pend_rs_d    = pend_rs_q;
        pend_data_d  = pend_data_q;
        idx_d        = idx_q;
        init_done_d  = init_done_q;
        ovf_d        = ovf_q;
        pop          = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (tc) begin
                    state_d    = SETUP;
                    cnt_d      = '0;
                    idx_d      = 2'd0;
                    cur_rs_d   = 1'b0;
                    cur_data_d = init_rom(2'd0);
                end
            end
            SETUP: if (tc) begin state_d = EN_HI; cnt_d = '0; end
            EN_HI: if (tc) begin state_d = HOLD;  cnt_d = '0; end
            HOLD:  if (tc) begin state_d = EXEC;  cnt_d = '0; end
            EXEC: begin
                if (tc) begin
                    cnt_d = '0;
                    if (!init_done_q && idx_q != 2'd3) begin
                        state_d    = SETUP;
                        idx_d      = idx_q + 2'd1;
                        cur_rs_d   = 1'b0;
                        cur_data_d = init_rom(idx_q + 2'd1);
                    end else begin
                        init_done_d = 1'b1;
                        if (pend_valid_q) begin
                            pop        = 1'b1;
                            state_d    = SETUP;
                            cur_rs_d   = pend_rs_q;
                            cur_data_d = pend_data_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            IDLE: begin
                cnt_d = '0;
                // a request captured on the final EXEC cycle is still owed a launch
                if (pend_valid_q) begin
                    pop        = 1'b1;
                    state_d    = SETUP;
                    cur_rs_d   = pend_rs_q;
                    cur_data_d = pend_data_q;
                end else if (go_pulse) begin
                    state_d    = SETUP;
                    cur_rs_d   = bus.lcd_reg_i[9];
                    cur_data_d = bus.lcd_reg_i[7:0];
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (go_pulse && !launch) begin
            if (!pend_valid_q || pop) begin
                pend_valid_d = 1'b1;
                pend_rs_d    = bus.lcd_reg_i[9];
                pend_data_d  = bus.lcd_reg_i[7:0];
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            go_q         <= 1'b0;
            on_q         <= 1'b0;
            cur_rs_q     <= 1'b0;
            cur_data_q   <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_rs_q    <= 1'b0;
            pend_data_q  <= 8'h00;
            idx_q        <= 2'd0;
            init_done_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            go_q         <= go_d;
            on_q         <= on_d;
            cur_rs_q     <= cur_rs_d;
            cur_data_q   <= cur_data_d;
            pend_valid_q <= pend_valid_d;
            pend_rs_q    <= pend_rs_d;
            pend_data_q  <= pend_data_d;
            idx_q        <= idx_d;
            init_done_q  <= init_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.lcd_on_o    = on_q;
    assign bus.lcd_en_o    = (state_q == EN_HI);
    assign bus.lcd_rs_o    = cur_rs_q;
    assign bus.lcd_rw_o    = 1'b0;
    assign bus.lcd_data_o  = cur_data_q;
    assign bus.lcd_busy_o  = (state_q != IDLE) | pend_valid_q | launch;
    assign bus.init_done_o = init_done_q;
    assign bus.lcd_ovf_o   = ovf_q;

    assign unused_bits = ^{bus.lcd_reg_i[30:11], bus.lcd_reg_i[8]};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: transaction-timeline reference model compared every cycle,
// plus directed timing checks and a randomized register-write phase.
module tb_lcd_ctrl;
    localparam int P_PWR = 10;
    localparam int P_S   = 1;
    localparam int P_E   = 3;
    localparam int P_H   = 1;
    localparam int P_X   = 5;
    localparam int P_C   = 20;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    lcd_ctrl_if bus();

    lcd_ctrl #(
        .T_PWRUP_CYC(P_PWR), .T_SETUP_CYC(P_S), .T_EN_CYC(P_E),
        .T_HOLD_CYC(P_H), .T_EXEC_CYC(P_X), .T_CLR_CYC(P_C)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one transaction timeline ----------------
    function automatic int dur_of(input logic rs, input logic [7:0] d);
        return P_S + P_E + P_H + ((!rs && d >= 8'h01 && d <= 8'h03) ? P_C : P_X);
    endfunction

    function automatic logic [7:0] rom_at(input int i);
        logic [7:0] tbl [4];
        tbl = '{8'h38, 8'h0C, 8'h01, 8'h06};
        return tbl[i];
    endfunction

    logic       m_valid = 1'b0;
    logic       m_pwr, m_active, m_done, m_ovf, m_pend_v, m_pend_rs, m_cur_rs, m_go_prev, m_on;
    int         m_pwr_cnt, m_off, m_idx;
    logic [7:0] m_cur_data, m_pend_data;
    logic [31:0] m_r;
    logic       m_go, m_idle, m_end, m_cont, m_pop, m_launch, m_cap, m_drop;

    task automatic m_start(input logic rs, input logic [7:0] d);
        m_active   = 1'b1;
        m_off      = 0;
        m_cur_rs   = rs;
        m_cur_data = d;
    endtask

    always @(negedge clk) begin
        m_r      = bus.lcd_reg_i;
        m_go     = m_r[10] && !m_go_prev;
        m_idle   = !m_pwr && !m_active;
        m_launch = m_idle && !m_pend_v && m_go;
        if (m_valid) begin
            chk1("en",   bus.lcd_en_o,    m_active && m_off >= P_S && m_off < P_S + P_E);
            chk1("rs",   bus.lcd_rs_o,    m_cur_rs);
            chk8("data", bus.lcd_data_o,  m_cur_data);
            chk1("rw",   bus.lcd_rw_o,    1'b0);
            chk1("busy", bus.lcd_busy_o,  m_pwr || m_active || m_pend_v || m_launch);
            chk1("done", bus.init_done_o, m_done);
            chk1("ovf",  bus.lcd_ovf_o,   m_ovf);
            chk1("on",   bus.lcd_on_o,    m_on);
        end
        if (!rst_ni) begin
            m_valid = 1'b1;
            m_pwr = 1'b1; m_pwr_cnt = 0; m_active = 1'b0; m_off = 0;
            m_cur_rs = 1'b0; m_cur_data = 8'h00; m_idx = 0; m_done = 1'b0;
            m_ovf = 1'b0; m_pend_v = 1'b0; m_pend_rs = 1'b0; m_pend_data = 8'h00;
            m_go_prev = 1'b0; m_on = 1'b0;
        end else if (m_valid) begin
            m_end  = m_active && (m_off == dur_of(m_cur_rs, m_cur_data) - 1);
            m_cont = m_end && !m_done && m_idx < 3;
            m_pop  = m_pend_v && ((m_end && !m_cont) || m_idle);
            m_cap  = m_go && !m_launch && (!m_pend_v || m_pop);
            m_drop = m_go && !m_launch && !m_cap;
            if (m_pwr) begin
                if (m_pwr_cnt == P_PWR - 1) begin
                    m_pwr = 1'b0;
                    m_idx = 0;
                    m_start(1'b0, rom_at(0));
                end else m_pwr_cnt++;
            end else if (m_active) begin
                if (m_end) begin
                    if (m_cont) begin
                        m_idx++;
                        m_start(1'b0, rom_at(m_idx));
                    end else begin
                        m_done = 1'b1;
                        if (m_pop) m_start(m_pend_rs, m_pend_data);
                        else m_active = 1'b0;
                    end
                end else m_off++;
            end else begin
                if (m_pop) m_start(m_pend_rs, m_pend_data);
                else if (m_launch) m_start(m_r[9], m_r[7:0]);
            end
            if (m_cap) begin
                m_pend_v = 1'b1; m_pend_rs = m_r[9]; m_pend_data = m_r[7:0];
            end else if (m_pop) m_pend_v = 1'b0;
            if (m_drop) m_ovf = 1'b1;
            m_go_prev = m_r[10];
            m_on      = m_r[31];
        end
    end

    // ---------------- directed helpers ----------------
    logic [31:0] seq [$];

    task automatic do_reset();
        @(posedge clk); #1;
        rst_ni = 1'b0;
        bus.lcd_reg_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_en",   bus.lcd_en_o,    1'b0);
        chk8("rst_data", bus.lcd_data_o,  8'h00);
        chk1("rst_busy", bus.lcd_busy_o,  1'b1);
        chk1("rst_done", bus.init_done_o, 1'b0);
    endtask

    task automatic init_seq();
        int first_en, done_at, nrise;
        logic prev_en;
        logic [7:0] seen [4];
        first_en = -1; done_at = -1; nrise = 0; prev_en = 1'b0;
        seen = '{8'h00, 8'h00, 8'h00, 8'h00};
        @(posedge clk); #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.lcd_en_o && !prev_en) begin
                if (nrise < 4) seen[nrise] = bus.lcd_data_o;
                if (nrise == 0) first_en = k;
                nrise++;
            end
            prev_en = bus.lcd_en_o;
            if (bus.init_done_o) begin
                done_at = k;
                break;
            end
        end
        chkn("init_first_en", first_en, P_PWR + P_S);
        chkn("init_done_at",  done_at,  65);
        chkn("init_pulses",   nrise,    4);
        chk8("init_d0", seen[0], 8'h38);
        chk8("init_d1", seen[1], 8'h0C);
        chk8("init_d2", seen[2], 8'h01);
        chk8("init_d3", seen[3], 8'h06);
        chk1("init_idle", bus.lcd_busy_o, 1'b0);
    endtask

    task automatic run_seq(input logic [7:0] bad_data,
                           output int busy_after, output int nrise, output int first_en,
                           output logic [7:0] d0, output logic [7:0] d1,
                           output logic rs1, output logic [7:0] data1, output logic saw_bad);
        logic prev_en;
        prev_en = 1'b0; busy_after = 0; nrise = 0; first_en = -1;
        d0 = 8'h00; d1 = 8'h00; rs1 = 1'b0; data1 = 8'h00; saw_bad = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (k < seq.size()) bus.lcd_reg_i = seq[k];
            @(negedge clk);
            if (k == 1) begin
                rs1   = bus.lcd_rs_o;
                data1 = bus.lcd_data_o;
            end
            if (bus.lcd_en_o && !prev_en) begin
                if (nrise == 0) begin
                    d0 = bus.lcd_data_o;
                    first_en = k;
                end else if (nrise == 1) d1 = bus.lcd_data_o;
                nrise++;
            end
            prev_en = bus.lcd_en_o;
            if (bus.lcd_en_o && bus.lcd_data_o == bad_data) saw_bad = 1'b1;
            if (k > 0) begin
                if (bus.lcd_busy_o) busy_after++;
                else break;
            end
        end
    endtask

    int ba, nr, fe;
    logic [7:0] d0, d1, dat1;
    logic r1, sb;
    logic [31:0] rv;

    initial begin
        rst_ni = 1'b0;
        bus.lcd_reg_i = 32'h0;

        do_reset();
        init_seq();

        // data write with GO held high for several cycles: one transaction only
        seq = {32'h641, 32'h641, 32'h641, 32'h641, 32'h641, 32'h241};
        run_seq(8'hFF, ba, nr, fe, d0, d1, r1, dat1, sb);
        chkn("wr41_busy", ba, 10);
        chkn("wr41_pulses", nr, 1);
        chkn("wr41_first_en", fe, 2);
        chk8("wr41_d0", d0, 8'h41);
        chk1("wr41_rs_c1", r1, 1'b1);
        chk8("wr41_data_c1", dat1, 8'h41);

        seq = {32'h401, 32'h001};
        run_seq(8'hFF, ba, nr, fe, d0, d1, r1, dat1, sb);
        chkn("clr_busy", ba, P_S + P_E + P_H + P_C);

        seq = {32'h404, 32'h004};
        run_seq(8'hFF, ba, nr, fe, d0, d1, r1, dat1, sb);
        chkn("cmd04_busy", ba, P_S + P_E + P_H + P_X);

        // three GO edges while busy: second pends, third is dropped
        seq = {32'h641, 32'h241, 32'h652, 32'h252, 32'h677, 32'h000};
        run_seq(8'h77, ba, nr, fe, d0, d1, r1, dat1, sb);
        chkn("b2b_busy", ba, 20);
        chkn("b2b_pulses", nr, 2);
        chk8("b2b_d0", d0, 8'h41);
        chk8("b2b_d1", d1, 8'h52);
        chk1("b2b_no77", sb, 1'b0);
        chk1("b2b_ovf", bus.lcd_ovf_o, 1'b1);

        // ON bit follows one cycle later and leaves busy alone
        @(posedge clk); #1;
        bus.lcd_reg_i = 32'h8000_0000;
        @(negedge clk);
        chk1("on_c0", bus.lcd_on_o, 1'b0);
        @(negedge clk);
        chk1("on_c1", bus.lcd_on_o, 1'b1);
        chk1("on_busy", bus.lcd_busy_o, 1'b0);
        @(posedge clk); #1;
        bus.lcd_reg_i = 32'h0;

        // reset during EN_HI
        @(posedge clk); #1;
        bus.lcd_reg_i = 32'h6AA;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.lcd_en_o) break;
        end
        chk1("pre_rst_en", bus.lcd_en_o, 1'b1);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        bus.lcd_reg_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk1("mid_rst_en",   bus.lcd_en_o,    1'b0);
        chk8("mid_rst_data", bus.lcd_data_o,  8'h00);
        chk1("mid_rst_busy", bus.lcd_busy_o,  1'b1);
        chk1("mid_rst_done", bus.init_done_o, 1'b0);
        init_seq();

        // randomized register traffic
        rv = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst_ni = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) == 0) rv[10] = ~rv[10];
            if ($urandom_range(0, 19) == 0) rv[31] = ~rv[31];
            rv[9]     = 1'($urandom_range(0, 1));
            rv[8]     = 1'($urandom_range(0, 1));
            rv[30:11] = 20'($urandom);
            rv[7:0]   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
            bus.lcd_reg_i = rv;
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        bus.lcd_reg_i = 32'h0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
